// File: rtl/cocofdc_pkg.sv
// Shared definitions for the CoCo FDC CPLD SRAM path: FSM state encoding,
// requester identifiers, SRAM geometry and the grant-selection helper.
package cocofdc_pkg;

  localparam int SRAM_ADDR_W      = 15;
  localparam int SRAM_DATA_W      = 8;
  localparam int SRAM_CYCLE_TICKS = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_ACCESS  = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_COCO = 1'b0,
    REQ_SPI  = 1'b1
  } req_id_t;

  // Choose the requester to serve from the IDLE state. A lone request always
  // wins; on a tie, round-robin hands the slot to whoever did not win last,
  // otherwise the SPI engine has priority.
  function automatic req_id_t arb_pick(input logic    coco_req,
                                       input logic    spi_req,
                                       input req_id_t last_grant,
                                       input logic    rr_en);
    if (coco_req && spi_req) begin
      if (rr_en) return (last_grant == REQ_SPI) ? REQ_COCO : REQ_SPI;
      else       return REQ_SPI;
    end else if (spi_req) begin
      return REQ_SPI;
    end else begin
      return REQ_COCO;
    end
  endfunction

endpackage

// File: rtl/sram_cycle_timer.sv
// ACCESS-phase down-counter for the SRAM arbiter. Loaded with CYCLE_TICKS-1
// while the FSM is in SETUP, counts down once per ACCESS tick and raises
// zero on the final ACCESS tick.
module sram_cycle_timer
  import cocofdc_pkg::*;
#(
  parameter int CYCLE_TICKS = SRAM_CYCLE_TICKS
) (
  input  logic clock_50,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic zero
);

  logic [3:0] count;

  // Down-counter: load wins over decrement, saturates at zero.
  always_ff @(posedge clock_50) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= 4'(CYCLE_TICKS - 1);
    end else if (enable && (count != '0)) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sram_arbiter.sv
// Shared 32Kx8 SRAM port arbiter for the CoCo FDC CPLD. Serialises CoCo bus
// and SPI engine accesses through IDLE -> SETUP -> ACCESS -> RELEASE and
// drives registered, glitch-free SRAM strobes.
// Build option: define SRAM_ARB_RR_EN for round-robin arbitration on
// simultaneous requests; otherwise SPI has fixed priority.
module sram_arbiter
  import cocofdc_pkg::*;
#(
  parameter int ADDR_W      = SRAM_ADDR_W,
  parameter int DATA_W      = SRAM_DATA_W,
  parameter int CYCLE_TICKS = SRAM_CYCLE_TICKS
) (
  input  logic              clock_50,
  input  logic              reset,
  input  logic              coco_req,
  input  logic              coco_we,
  input  logic [ADDR_W-1:0] coco_addr,
  input  logic [DATA_W-1:0] coco_wdata,
  output logic              coco_ack,
  output logic [DATA_W-1:0] coco_rdata,
  input  logic              spi_req,
  input  logic              spi_we,
  input  logic [ADDR_W-1:0] spi_addr,
  input  logic [DATA_W-1:0] spi_wdata,
  output logic              spi_ack,
  output logic [DATA_W-1:0] spi_rdata,
  output logic [ADDR_W-1:0] sram_addrbus,
  output logic [DATA_W-1:0] sram_dout,
  input  logic [DATA_W-1:0] sram_din,
  output logic              sram_dq_oe,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic              busy
);

  arb_state_t        state, state_nxt;
  req_id_t           grant, grant_nxt;
  req_id_t           pick;
  logic              cur_we, we_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] dout_nxt;
  logic              timer_load, timer_en, timer_zero;
  logic              we_n_nxt, oe_n_nxt, dq_oe_nxt;
  logic              coco_ack_nxt, spi_ack_nxt;
  logic              capture;

`ifdef SRAM_ARB_RR_EN
  req_id_t last_grant;

  assign pick = arb_pick(coco_req, spi_req, last_grant, 1'b1);

  // Remember the winner of every grant so the next tie goes the other way.
  always_ff @(posedge clock_50) begin
    if (reset) begin
      last_grant <= REQ_COCO;
    end else if ((state == ST_IDLE) && (coco_req || spi_req)) begin
      last_grant <= pick;
    end
  end
`else
  assign pick = arb_pick(coco_req, spi_req, REQ_COCO, 1'b0);
`endif

  sram_cycle_timer #(
    .CYCLE_TICKS (CYCLE_TICKS)
  ) u_timer (
    .clock_50 (clock_50),
    .reset    (reset),
    .load     (timer_load),
    .enable   (timer_en),
    .zero     (timer_zero)
  );

  // Next-state, grant latch and next-tick strobe decode.
  always_comb begin
    // NOTE: every variable below gets a default first so no path infers a latch.
    state_nxt  = state;
    grant_nxt  = grant;
    we_nxt     = cur_we;
    addr_nxt   = sram_addrbus;
    dout_nxt   = sram_dout;
    timer_load = 1'b0;
    timer_en   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (coco_req || spi_req) begin
          grant_nxt = pick;
          state_nxt = ST_SETUP;
          if (pick == REQ_SPI) begin
            we_nxt   = spi_we;
            addr_nxt = spi_addr;
            dout_nxt = spi_wdata;
          end else begin
            we_nxt   = coco_we;
            addr_nxt = coco_addr;
            dout_nxt = coco_wdata;
          end
        end
      end
      ST_SETUP: begin
        timer_load = 1'b1;
        state_nxt  = ST_ACCESS;
      end
      ST_ACCESS: begin
        timer_en = 1'b1;
        if (timer_zero) state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Strobes are decoded from the upcoming state and registered, so the pins
    // never glitch. Write strobe only in ACCESS; output enable only on reads,
    // so we_n/oe_n and dq_oe/oe_n can never be active together.
    we_n_nxt     = !((state_nxt == ST_ACCESS) && we_nxt);
    oe_n_nxt     = !(((state_nxt == ST_SETUP) || (state_nxt == ST_ACCESS)) && !we_nxt);
    dq_oe_nxt    = we_nxt && (state_nxt != ST_IDLE);
    coco_ack_nxt = (state_nxt == ST_RELEASE) && (grant_nxt == REQ_COCO);
    spi_ack_nxt  = (state_nxt == ST_RELEASE) && (grant_nxt == REQ_SPI);
  end

  // Read data is taken on the last ACCESS tick, while oe_n is still low.
  assign capture = (state == ST_ACCESS) && timer_zero && !cur_we;

  // FSM state register plus registered SRAM pins and acknowledges.
  always_ff @(posedge clock_50) begin
    if (reset) begin
      state        <= ST_IDLE;
      grant        <= REQ_COCO;
      cur_we       <= 1'b0;
      sram_addrbus <= '0;
      sram_dout    <= '0;
      sram_we_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
      sram_dq_oe   <= 1'b0;
      coco_ack     <= 1'b0;
      spi_ack      <= 1'b0;
    end else begin
      state        <= state_nxt;
      grant        <= grant_nxt;
      cur_we       <= we_nxt;
      sram_addrbus <= addr_nxt;
      sram_dout    <= dout_nxt;
      sram_we_n    <= we_n_nxt;
      sram_oe_n    <= oe_n_nxt;
      sram_dq_oe   <= dq_oe_nxt;
      coco_ack     <= coco_ack_nxt;
      spi_ack      <= spi_ack_nxt;
    end
  end

  // Per-requester read data, held until that requester's next read.
  always_ff @(posedge clock_50) begin
    if (reset) begin
      coco_rdata <= '0;
      spi_rdata  <= '0;
    end else if (capture) begin
      if (grant == REQ_SPI) spi_rdata  <= sram_din;
      else                  coco_rdata <= sram_din;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios followed by
// randomized single and paired requests against a transaction-level model
// (service order, fixed latencies, expected memory image).
module tb_sram_arbiter;

  localparam int TICKS  = 4;
  localparam int LAT    = TICKS + 2;   // request cycle to ack cycle
  localparam int PERIOD = TICKS + 3;   // one full access slot
`ifdef SRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clock_50 = 1'b0;
  logic        reset = 1'b1;
  logic        coco_req = 1'b0, coco_we = 1'b0;
  logic [14:0] coco_addr = '0;
  logic [7:0]  coco_wdata = '0;
  logic        coco_ack;
  logic [7:0]  coco_rdata;
  logic        spi_req = 1'b0, spi_we = 1'b0;
  logic [14:0] spi_addr = '0;
  logic [7:0]  spi_wdata = '0;
  logic        spi_ack;
  logic [7:0]  spi_rdata;
  logic [14:0] sram_addrbus;
  logic [7:0]  sram_dout, sram_din;
  logic        sram_dq_oe, sram_we_n, sram_oe_n, busy;

  int vectors = 0;
  int miscompares = 0;

  // External SRAM pin model and the bench's own expected memory image.
  logic [7:0] sram_mem [0:32767];
  logic [7:0] ref_mem  [0:32767];
  logic [7:0] model_c_rdata = '0;
  logic [7:0] model_s_rdata = '0;
  bit         model_last_spi = 1'b0;

  sram_arbiter dut (
    .clock_50 (clock_50), .reset (reset),
    .coco_req (coco_req), .coco_we (coco_we), .coco_addr (coco_addr),
    .coco_wdata (coco_wdata), .coco_ack (coco_ack), .coco_rdata (coco_rdata),
    .spi_req (spi_req), .spi_we (spi_we), .spi_addr (spi_addr),
    .spi_wdata (spi_wdata), .spi_ack (spi_ack), .spi_rdata (spi_rdata),
    .sram_addrbus (sram_addrbus), .sram_dout (sram_dout), .sram_din (sram_din),
    .sram_dq_oe (sram_dq_oe), .sram_we_n (sram_we_n), .sram_oe_n (sram_oe_n),
    .busy (busy)
  );

  always #10 clock_50 = ~clock_50;

  // SRAM device: writes while we_n low and data driven, reads while oe_n low.
  always @(posedge clock_50) begin
    if (!sram_we_n && sram_dq_oe) sram_mem[sram_addrbus] <= sram_dout;
  end
  assign sram_din = !sram_oe_n ? sram_mem[sram_addrbus] : 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bus-safety monitor, every cycle outside reset.
  always @(negedge clock_50) begin
    if (!reset) begin
      check("we_oe_overlap", 32'(!sram_we_n && !sram_oe_n), 32'd0);
      check("dq_oe_contention", 32'(sram_dq_oe && !sram_oe_n), 32'd0);
      check("dual_ack", 32'(coco_ack && spi_ack), 32'd0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Model of one served transaction.
  task automatic model_serve(input bit is_spi, input bit we, input logic [14:0] a, input logic [7:0] d);
    if (we) ref_mem[a] = d;
    else if (is_spi) model_s_rdata = ref_mem[a];
    else model_c_rdata = ref_mem[a];
    model_last_spi = is_spi;
  endtask

  // Issue up to one request per requester in the same cycle and check the
  // service order, ack latency, strobe widths and returned data.
  task automatic run_pair(input bit c_en, input bit c_we, input logic [14:0] c_addr, input logic [7:0] c_wd,
                          input bit s_en, input bit s_we, input logic [14:0] s_addr, input logic [7:0] s_wd,
                          input bit drop_early, input string tag);
    bit spi_first;
    int exp_c_lat, exp_s_lat, c_lat, s_lat, c_acks, s_acks;
    int we_low, oe_low, exp_we_low, exp_oe_low, last_cnt;
    spi_first = (c_en && s_en) ? (RR ? !model_last_spi : 1'b1) : s_en;
    exp_c_lat = 0; exp_s_lat = 0;
    if (s_en) exp_s_lat = (c_en && !spi_first) ? LAT + PERIOD : LAT;
    if (c_en) exp_c_lat = (s_en && spi_first) ? LAT + PERIOD : LAT;
    if (spi_first) begin
      if (s_en) model_serve(1'b1, s_we, s_addr, s_wd);
      if (c_en) model_serve(1'b0, c_we, c_addr, c_wd);
    end else begin
      if (c_en) model_serve(1'b0, c_we, c_addr, c_wd);
      if (s_en) model_serve(1'b1, s_we, s_addr, s_wd);
    end
    exp_we_low = TICKS * (int'(c_en && c_we) + int'(s_en && s_we));
    exp_oe_low = (TICKS + 1) * (int'(c_en && !c_we) + int'(s_en && !s_we));
    last_cnt = ((exp_c_lat > exp_s_lat) ? exp_c_lat : exp_s_lat) + 2;
    c_lat = 0; s_lat = 0; c_acks = 0; s_acks = 0; we_low = 0; oe_low = 0;

    coco_req = c_en; coco_we = c_we; coco_addr = c_addr; coco_wdata = c_wd;
    spi_req  = s_en; spi_we  = s_we; spi_addr  = s_addr; spi_wdata  = s_wd;
    for (int cnt = 1; cnt <= last_cnt; cnt++) begin
      @(negedge clock_50);
      if (!sram_we_n) we_low++;
      if (!sram_oe_n) oe_low++;
      if (coco_ack) begin
        c_acks++;
        if (c_lat == 0) c_lat = cnt;
        if (!c_we) check({tag, ":coco_rdata@ack"}, 32'(coco_rdata), 32'(model_c_rdata));
        coco_req = 1'b0;
      end
      if (spi_ack) begin
        s_acks++;
        if (s_lat == 0) s_lat = cnt;
        if (!s_we) check({tag, ":spi_rdata@ack"}, 32'(spi_rdata), 32'(model_s_rdata));
        spi_req = 1'b0;
      end
      if (drop_early && cnt == 1) begin
        coco_req = 1'b0;
        spi_req  = 1'b0;
      end
      // Once granted, the requester's bus fields must no longer matter.
      if (c_en && cnt >= exp_c_lat - 5) begin
        coco_we = 1'($urandom); coco_addr = 15'($urandom); coco_wdata = 8'($urandom);
      end
      if (s_en && cnt >= exp_s_lat - 5) begin
        spi_we = 1'($urandom); spi_addr = 15'($urandom); spi_wdata = 8'($urandom);
      end
    end
    coco_req = 1'b0; spi_req = 1'b0;
    check({tag, ":coco_ack_cycle"}, 32'(c_lat), 32'(exp_c_lat));
    check({tag, ":spi_ack_cycle"}, 32'(s_lat), 32'(exp_s_lat));
    check({tag, ":coco_ack_pulses"}, 32'(c_acks), 32'(c_en));
    check({tag, ":spi_ack_pulses"}, 32'(s_acks), 32'(s_en));
    check({tag, ":we_n_low_ticks"}, 32'(we_low), 32'(exp_we_low));
    check({tag, ":oe_n_low_ticks"}, 32'(oe_low), 32'(exp_oe_low));
    check({tag, ":busy_after"}, 32'(busy), 32'd0);
    check({tag, ":dq_oe_after"}, 32'(sram_dq_oe), 32'd0);
    check({tag, ":coco_rdata_held"}, 32'(coco_rdata), 32'(model_c_rdata));
    check({tag, ":spi_rdata_held"}, 32'(spi_rdata), 32'(model_s_rdata));
  endtask

  initial begin
    int acks_seen, ack_cyc0, ack_cyc1;
    logic [7:0] rd0, rd1;
    bit c_en, s_en;

    for (int i = 0; i < 32768; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      sram_mem[i] <= v;
      ref_mem[i] = v;
    end
    sram_mem[15'h0100] <= 8'h5A;
    ref_mem[15'h0100] = 8'h5A;

    // Reset state.
    repeat (3) @(negedge clock_50);
    check("rst:we_n", 32'(sram_we_n), 32'd1);
    check("rst:oe_n", 32'(sram_oe_n), 32'd1);
    check("rst:dq_oe", 32'(sram_dq_oe), 32'd0);
    check("rst:busy", 32'(busy), 32'd0);
    check("rst:acks", 32'({coco_ack, spi_ack}), 32'd0);
    check("rst:rdata", 32'({coco_rdata, spi_rdata}), 32'd0);
    check("rst:addr_dout", 32'({sram_addrbus, sram_dout}), 32'd0);
    reset = 1'b0;
    @(negedge clock_50);

    // 1: SPI write alone.
    run_pair(1'b0, 1'b0, 15'h0, 8'h0, 1'b1, 1'b1, 15'h1234, 8'hA5, 1'b0, "t1_spi_write");
    // 3: simultaneous requests (fixed: SPI first; RR with last=SPI: CoCo first).
    run_pair(1'b1, 1'b0, 15'h1234, 8'h00, 1'b1, 1'b1, 15'h0042, 8'h3C, 1'b0, "t3_collide");
    // 2: CoCo read of a known location.
    run_pair(1'b1, 1'b0, 15'h0100, 8'h00, 1'b0, 1'b0, 15'h0, 8'h0, 1'b0, "t2_coco_read");
    check("t2:coco_rdata_5a", 32'(coco_rdata), 32'h5A);

    // 4: back-to-back SPI reads, request kept high across the ack.
    spi_req = 1'b1; spi_we = 1'b0; spi_addr = 15'h0000;
    acks_seen = 0; ack_cyc0 = 0; ack_cyc1 = 0; rd0 = '0; rd1 = '0;
    for (int cnt = 1; cnt <= 16; cnt++) begin
      @(negedge clock_50);
      if (cnt == 7) check("t4:busy_gap", 32'(busy), 32'd0);
      if (cnt == 8) check("t4:second_setup", 32'(busy), 32'd1);
      if (spi_ack) begin
        acks_seen++;
        if (acks_seen == 1) begin
          ack_cyc0 = cnt; rd0 = spi_rdata; spi_addr = 15'h0001;
        end else begin
          ack_cyc1 = cnt; rd1 = spi_rdata; spi_req = 1'b0;
        end
      end
    end
    spi_req = 1'b0;
    check("t4:ack0_cycle", 32'(ack_cyc0), 32'(LAT));
    check("t4:ack1_cycle", 32'(ack_cyc1), 32'(LAT + PERIOD));
    check("t4:rdata0", 32'(rd0), 32'(ref_mem[0]));
    check("t4:rdata1", 32'(rd1), 32'(ref_mem[1]));
    model_s_rdata = ref_mem[1];
    model_last_spi = 1'b1;

    // 6: request dropped during SETUP still completes once.
    run_pair(1'b0, 1'b0, 15'h0, 8'h0, 1'b1, 1'b1, 15'h0077, 8'h96, 1'b1, "t6_drop_setup");
    run_pair(1'b0, 1'b0, 15'h0, 8'h0, 1'b1, 1'b0, 15'h0077, 8'h00, 1'b0, "t6_readback");

    // 5: reset during the second ACCESS tick of a write aborts it.
    spi_req = 1'b1; spi_we = 1'b1; spi_addr = 15'h7FFF; spi_wdata = 8'hC3;
    repeat (3) @(negedge clock_50);
    check("t5:we_n_active", 32'(sram_we_n), 32'd0);
    reset = 1'b1; spi_req = 1'b0;
    @(negedge clock_50);
    check("t5:we_n", 32'(sram_we_n), 32'd1);
    check("t5:dq_oe", 32'(sram_dq_oe), 32'd0);
    check("t5:busy", 32'(busy), 32'd0);
    check("t5:ack", 32'(spi_ack), 32'd0);
    check("t5:rdata_cleared", 32'({coco_rdata, spi_rdata}), 32'd0);
    reset = 1'b0;
    model_c_rdata = '0; model_s_rdata = '0; model_last_spi = 1'b0;
    acks_seen = 0;
    repeat (8) begin
      @(negedge clock_50);
      if (coco_ack || spi_ack) acks_seen++;
    end
    check("t5:no_ack_after_abort", 32'(acks_seen), 32'd0);

    // Randomized traffic over a small address window so reads hit earlier writes.
    for (int it = 0; it < 60; it++) begin
      c_en = 1'($urandom);
      s_en = 1'($urandom);
      if (!c_en && !s_en) s_en = 1'b1;
      run_pair(c_en, 1'($urandom), 15'($urandom_range(0, 255)), 8'($urandom),
               s_en, 1'($urandom), 15'($urandom_range(0, 255)), 8'($urandom),
               1'b0, $sformatf("rand%0d", it));
      repeat ($urandom_range(0, 2)) @(negedge clock_50);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
